// File: rtl/rx_timer.sv
// rx_timer: enabled-cycle counter; registered one-cycle timer_out pulse plus sticky expired on wrap, no backpressure.
// Optional RX_TIMER_DEBUG_EN exposes the live counter on count; otherwise count is tied to 0.
module rx_timer #(
  parameter int TIMER_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  output logic                   timer_out,
  output logic                   expired,
  output logic [TIMER_WIDTH-1:0] count
);

  localparam logic [TIMER_WIDTH-1:0] TERMINAL = {TIMER_WIDTH{1'b1}};

  logic [TIMER_WIDTH-1:0] counter;
  logic                   at_terminal;

  assign at_terminal = (counter == TERMINAL);

  // clear outranks enable, so a clear landing on terminal count suppresses the pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter   <= '0;
      timer_out <= 1'b0;
      expired   <= 1'b0;
    end else if (clear) begin
      counter   <= '0;
      timer_out <= 1'b0;
      expired   <= 1'b0;
    end else if (enable) begin
      if (at_terminal) begin
        counter   <= '0;
        timer_out <= 1'b1;
        expired   <= 1'b1;
      end else begin
        counter   <= counter + 1'b1;
        timer_out <= 1'b0;
      end
    end else begin
      timer_out <= 1'b0;
    end
  end

`ifdef RX_TIMER_DEBUG_EN
  assign count = counter;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_rx_timer.sv
// Randomized and directed bench for rx_timer at widths 4 and 12, checked against an enabled-edge tally model.
module tb_rx_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        to4, ex4, to12, ex12;
  logic [3:0]  cnt4;
  logic [11:0] cnt12;

  rx_timer #(.TIMER_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .timer_out(to4), .expired(ex4), .count(cnt4)
  );

  rx_timer #(.TIMER_WIDTH(12)) dut12 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .timer_out(to12), .expired(ex12), .count(cnt12)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  int     pulses4 = 0;
  // Model: number of enabled edges since the last clear/reset, per instance.
  longint n4 = 0;
  longint n12 = 0;
  logic   p4 = 1'b0;
  logic   p12 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_cnt4, e_cnt12;
`ifdef RX_TIMER_DEBUG_EN
    e_cnt4  = 32'(n4 % 16);
    e_cnt12 = 32'(n12 % 4096);
`else
    e_cnt4  = 32'd0;
    e_cnt12 = 32'd0;
`endif
    check({tag, ":to4"},   {31'b0, to4},  {31'b0, p4});
    check({tag, ":ex4"},   {31'b0, ex4},  {31'b0, (n4 >= 16)});
    check({tag, ":cnt4"},  {28'b0, cnt4}, e_cnt4);
    check({tag, ":to12"},  {31'b0, to12}, {31'b0, p12});
    check({tag, ":ex12"},  {31'b0, ex12}, {31'b0, (n12 >= 4096)});
    check({tag, ":cnt12"}, {20'b0, cnt12}, e_cnt12);
  endtask

  task automatic step(input logic en, input logic clr, input string tag);
    @(negedge clk);
    enable = en;
    clear  = clr;
    @(posedge clk);
    if (clr) begin
      n4 = 0; n12 = 0; p4 = 1'b0; p12 = 1'b0;
    end else if (en) begin
      n4++; n12++;
      p4  = (n4 % 16 == 0);
      p12 = (n12 % 4096 == 0);
    end else begin
      p4 = 1'b0; p12 = 1'b0;
    end
    #1;
    if (to4) pulses4++;
    check_all(tag);
  endtask

  // Reset is raised between clock edges and checked before any edge arrives.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    enable = 1'b0;
    clear  = 1'b0;
    reset  = 1'b1;
    n4 = 0; n12 = 0; p4 = 1'b0; p12 = 1'b0;
    #1;
    check_all(tag);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset("reset_state");

    // Width 4, enable held 40 cycles: pulses after edges 16 and 32, counter ends at 8.
    pulses4 = 0;
    repeat (40) step(1'b1, 1'b0, "w4_run40");
    check("w4_pulse_count", pulses4, 32'd2);

    // Width 12 from zero: single pulse after exactly 4096 enabled edges.
    do_reset("reset_before_w12");
    repeat (4095) step(1'b1, 1'b0, "w12_run");
    check("w12_no_early_pulse", {31'b0, to12}, 32'd0);
    step(1'b1, 1'b0, "w12_edge4096");
    check("w12_pulse", {31'b0, to12}, 32'd1);
    check("w12_expired", {31'b0, ex12}, 32'd1);
    step(1'b1, 1'b0, "w12_after");
    check("w12_pulse_one_cycle", {31'b0, to12}, 32'd0);

    // Reset mid-count while both flags are sticky.
    repeat (99) step(1'b1, 1'b0, "to_100");
    do_reset("reset_mid_count");
    check("mid_reset_expired12", {31'b0, ex12}, 32'd0);

    // Alternating enable: pulse after 4096 enabled edges, about 8192 clocks.
    for (int i = 0; i < 8194; i++) step(i % 2 == 0, 1'b0, "alt_enable");

    // Clear arriving with enable exactly at terminal count suppresses the pulse.
    do_reset("reset_before_clr");
    repeat (4095) step(1'b1, 1'b0, "clr_prep");
    step(1'b1, 1'b1, "clr_at_tc");
    check("clr_at_tc_no_pulse", {31'b0, to12}, 32'd0);
    check("clr_at_tc_expired", {31'b0, ex12}, 32'd0);
    repeat (5) step(1'b1, 1'b0, "post_clr");

    // Random mix of enable, clear and asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rand_reset");
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_timer.md
RX_TIMER -- requirements
Module: rx_timer

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 12: counter width; legal range 2..32.
REQ-002 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: count-enable; counter advances only in cycles where it is high.
REQ-005 SHALL have port clear, input, 1: synchronous restart; counter to 0 and expired to 0 at next edge.
REQ-006 SHALL have port timer_out, output, 1: registered one-cycle pulse on terminal count.
REQ-007 SHALL have port expired, output, 1: sticky flag set on terminal count, cleared by clear or reset.
REQ-008 SHALL have port count, output, TIMER_WIDTH: debug view of the counter (see REQ-019).

Function
REQ-009 Counter SHALL be unsigned, TIMER_WIDTH bits; terminal count TC = 2^TIMER_WIDTH-1 (4095 at default).
REQ-010 enable=1, clear=0, counter<TC: counter SHALL increment by 1 at the edge.
REQ-011 enable=1, clear=0, counter==TC: counter SHALL wrap to 0, timer_out=1 for exactly the next cycle, expired set.
REQ-012 timer_out SHALL therefore first assert at the edge after the 2^TIMER_WIDTH-th enabled cycle (4096 at default), counting from counter 0.
REQ-013 enable=0, clear=0: counter SHALL hold; timer_out SHALL be 0; expired holds.
REQ-014 clear=1 SHALL take priority over enable: counter=0, timer_out=0, expired=0 at the edge, regardless of enable or counter value.
REQ-015 clear and terminal count in the same cycle: clear SHALL win; no timer_out pulse.
REQ-016 Non-contiguous enable cycles SHALL accumulate; gaps do not restart counting.
REQ-017 timer_out SHALL be driven directly from a flop (no combinational path from inputs).
REQ-018 After wrap, counting SHALL continue while enable=1; a further pulse follows after another 2^TIMER_WIDTH enabled cycles.

Reset
REQ-020 reset=1 SHALL immediately (asynchronously) force counter=0, timer_out=0, expired=0, count=0.
REQ-021 Reset deassertion SHALL resume normal behaviour from the first subsequent rising edge; reset mid-count discards accumulated count.
REQ-022 Reset SHALL take priority over clear and enable.

Configuration
REQ-019 Macro RX_TIMER_DEBUG_EN: defined -> count output SHALL mirror the internal counter every cycle; undefined -> count SHALL be tied to 0 and no extra logic added; timer_out/expired behaviour identical in both builds.

Verification
REQ-023 Reset asserted mid-count (counter=100) -> counter, timer_out, expired all 0 without waiting for clk.
REQ-024 TIMER_WIDTH=12, enable held 1 from counter 0 -> timer_out high in exactly one cycle, after 4096 enabled edges; expired=1 thereafter.
REQ-025 enable toggled 1/0 alternately from counter 0 -> pulse after 4096 enabled edges (about 8192 clocks); count holds in off cycles.
REQ-026 clear pulsed at counter=4095 with enable=1 -> no timer_out; counter=0; expired=0.
REQ-027 TIMER_WIDTH=4, enable held 40 cycles -> timer_out pulses after enabled edges 16 and 32; counter=8 at end.
REQ-028 Build without RX_TIMER_DEBUG_EN -> count constantly 0; timer_out timing identical to REQ-024.
